// File: rtl/mux_n_1_pipe_pkg.sv
// Shared definitions for the N:1 select mux with registered valid/ready output and skid.
// Occupancy encodings double as the controller state.
package mux_n_1_pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/mux_n_1_pipe_word_reg.sv
// One storage slot of the output stage: data word, select-error flag and valid bit.
// rst clears everything; clr drops only the valid bit so data stays as a don't-care.
module pipe_word_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_err,
    output logic [WIDTH-1:0] q_data,
    output logic             q_err,
    output logic             q_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_data  <= '0;
            q_err   <= 1'b0;
            q_valid <= 1'b0;
        end else if (ld) begin
            q_data  <= d_data;
            q_err   <= d_err;
            q_valid <= 1'b1;
        end else if (clr) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_n_1_pipe.sv
// N-input WIDTH-bit select mux feeding a head register H and a skid register S,
// with valid/ready flow control, flush and out-of-range select flagging.
//
// state     | meaning
// OCC_EMPTY | H and S empty
// OCC_ONE   | H holds the head word, S empty
// OCC_TWO   | H and S both hold words, in_ready low
module mux_n_1_pipe
    import mux_n_1_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              occ
);

    logic [WIDTH-1:0]  masked [NUM_IN];
    logic [NUM_IN-1:0] hit;
    logic [WIDTH-1:0]  new_data;
    logic              new_err;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_sel
        assign hit[i]    = (sel == SEL_W'(i));
        assign masked[i] = hit[i] ? in_data[i*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        new_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            new_data = new_data | masked[k];
        end
    end

    // no input matched: the word goes out as zero with the error flag set
    assign new_err = ~|hit;

    occ_e             occ_q, occ_nxt;
    logic [WIDTH-1:0] h_data, s_data, h_d_data;
    logic             h_err, s_err, h_d_err;
    logic             h_valid, s_valid;
    logic             h_ld, h_clr, s_ld, s_clr, h_from_s;
    logic             accept, pop;

    assign in_ready = ~rst & ~flush & (occ_q != OCC_TWO);
    assign accept   = in_valid & in_ready;
    assign pop      = h_valid & out_ready;

    always_comb begin
        h_ld     = 1'b0;
        h_clr    = 1'b0;
        s_ld     = 1'b0;
        s_clr    = 1'b0;
        h_from_s = 1'b0;
        occ_nxt  = occ_q;
        if (flush) begin
            h_clr   = 1'b1;
            s_clr   = 1'b1;
            occ_nxt = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        h_ld    = 1'b1;
                        occ_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        h_ld = 1'b1;
                    end else if (accept) begin
                        s_ld    = 1'b1;
                        occ_nxt = OCC_TWO;
                    end else if (pop) begin
                        h_clr   = 1'b1;
                        occ_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        h_ld     = 1'b1;
                        h_from_s = 1'b1;
                        s_clr    = 1'b1;
                        occ_nxt  = OCC_ONE;
                    end
                end
                default: begin
                    h_clr   = 1'b1;
                    s_clr   = 1'b1;
                    occ_nxt = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_nxt;
        end
    end

    assign h_d_data = h_from_s ? s_data : new_data;
    assign h_d_err  = h_from_s ? s_err  : new_err;

    pipe_word_reg #(.WIDTH(WIDTH)) u_head (
        .clk     (clk),
        .rst     (rst),
        .ld      (h_ld),
        .clr     (h_clr),
        .d_data  (h_d_data),
        .d_err   (h_d_err),
        .q_data  (h_data),
        .q_err   (h_err),
        .q_valid (h_valid)
    );

    pipe_word_reg #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .ld      (s_ld),
        .clr     (s_clr),
        .d_data  (new_data),
        .d_err   (new_err),
        .q_data  (s_data),
        .q_err   (s_err),
        .q_valid (s_valid)
    );

    assign out_data    = h_data;
    assign out_sel_err = h_err;
    assign out_valid   = h_valid;
    assign occ         = 2'(occ_q);

    // S.valid only feeds the occupancy invariant, which occ_q already tracks
    logic unused_s_valid;
    assign unused_s_valid = s_valid;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Directed bench for mux_n_1_pipe: driver pushes hand-computed words on accept,
// a monitor pops and compares on every output handshake.
module tb_mux_n_1_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, out_ready;
    logic [1:0]  sel;
    logic [63:0] in_data;
    logic        in_ready, out_sel_err, out_valid;
    logic [15:0] out_data;
    logic [1:0]  occ;

    logic        in_valid3, in_ready3, flush3, out_ready3;
    logic [1:0]  sel3;
    logic [47:0] in_data3;
    logic        out_sel_err3, out_valid3;
    logic [15:0] out_data3;
    logic [1:0]  occ3;

    mux_n_1_pipe #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel_err(out_sel_err),
        .out_valid(out_valid), .out_ready(out_ready), .occ(occ)
    );

    mux_n_1_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .flush(flush3), .out_data(out_data3), .out_sel_err(out_sel_err3),
        .out_valid(out_valid3), .out_ready(out_ready3), .occ(occ3)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic ordy,
                        input logic fl, input logic r, input logic [15:0] ed, input logic ee);
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        if (in_valid && in_ready) exp_q.push_back('{data: ed, err: ee});
        @(posedge clk);
        #1;
        if (fl || r) exp_q.delete();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got %h, expected no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", 32'(out_data), 32'(e.data));
                    chk("pop_err", 32'(out_sel_err), 32'(e.err));
                end
            end
        end
    end

    logic [15:0] stream_exp [4];

    initial begin
        stream_exp = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        in_data    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        in_data3   = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        in_valid3 = 1'b0; sel3 = 2'd0; flush3 = 1'b0; out_ready3 = 1'b0;

        step(0, 0, 1, 0, 1, 16'h0, 0);
        step(0, 0, 1, 0, 1, 16'h0, 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);

        step(1, 2, 1, 0, 0, 16'hCCCC, 0);
        chk("basic_data", 32'(out_data), 32'h0000CCCC);
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_err", 32'(out_sel_err), 0);
        chk("basic_occ", 32'(occ), 1);
        step(0, 0, 1, 0, 0, 16'h0, 0);
        chk("basic_drain_valid", 32'(out_valid), 0);

        for (int i = 0; i < 4; i++) begin
            step(1, 2'(i), 1, 0, 0, stream_exp[i], 0);
            chk("stream_data", 32'(out_data), 32'(stream_exp[i]));
            chk("stream_occ", 32'(occ), 1);
            chk("stream_in_ready", 32'(in_ready), 1);
        end
        step(0, 0, 1, 0, 0, 16'h0, 0);
        chk("stream_drain_valid", 32'(out_valid), 0);

        step(1, 1, 0, 0, 0, 16'hBBBB, 0);
        chk("bp_occ1", 32'(occ), 1);
        step(1, 3, 0, 0, 0, 16'hDDDD, 0);
        chk("bp_occ2", 32'(occ), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_hold_data", 32'(out_data), 32'h0000BBBB);
        step(1, 0, 0, 0, 0, 16'hAAAA, 0);
        chk("bp_third_occ", 32'(occ), 2);
        chk("bp_third_data", 32'(out_data), 32'h0000BBBB);
        step(0, 0, 1, 0, 0, 16'h0, 0);
        chk("skid_data", 32'(out_data), 32'h0000DDDD);
        chk("skid_occ", 32'(occ), 1);
        step(0, 0, 1, 0, 0, 16'h0, 0);
        chk("skid_drain_valid", 32'(out_valid), 0);
        chk("skid_drain_occ", 32'(occ), 0);
        chk("skid_q_empty", 32'(exp_q.size()), 0);

        step(1, 1, 0, 0, 0, 16'hBBBB, 0);
        step(1, 3, 0, 0, 0, 16'hDDDD, 0);
        chk("fl_pre_occ", 32'(occ), 2);
        step(1, 2, 0, 1, 0, 16'hCCCC, 0);
        chk("fl_occ", 32'(occ), 0);
        chk("fl_valid", 32'(out_valid), 0);
        step(0, 0, 1, 0, 0, 16'h0, 0);
        chk("fl_after_occ", 32'(occ), 0);
        chk("fl_after_valid", 32'(out_valid), 0);
        chk("fl_after_in_ready", 32'(in_ready), 1);

        step(1, 0, 0, 0, 0, 16'hAAAA, 0);
        step(1, 1, 0, 0, 0, 16'hBBBB, 0);
        chk("rm_pre_occ", 32'(occ), 2);
        step(1, 2, 1, 1, 1, 16'hCCCC, 0);
        chk("rm_valid", 32'(out_valid), 0);
        chk("rm_data", 32'(out_data), 0);
        chk("rm_err", 32'(out_sel_err), 0);
        chk("rm_occ", 32'(occ), 0);
        chk("rm_in_ready", 32'(in_ready), 0);
        step(0, 0, 1, 0, 0, 16'h0, 0);
        chk("rm_after_in_ready", 32'(in_ready), 1);
        chk("rm_after_valid", 32'(out_valid), 0);

        sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b0;
        @(posedge clk); #1;
        chk("oor_data", 32'(out_data3), 0);
        chk("oor_err", 32'(out_sel_err3), 1);
        chk("oor_valid", 32'(out_valid3), 1);
        sel3 = 2'd2; out_ready3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        chk("lastin_data", 32'(out_data3), 32'h0000CCCC);
        chk("lastin_err", 32'(out_sel_err3), 0);
        @(posedge clk); #1;
        chk("lastin_drain_valid", 32'(out_valid3), 0);

        chk("final_q_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_n_1_pipe.md
Name: mux_n_1_pipe

Overview:
- Parametrised N-input, WIDTH-bit select mux with a registered valid/ready output stage and a 2-entry skid buffer.
- Generalises the 16-bit 2:1 combinational mux to any input count and width.
- Adds flow control, flush and out-of-range select detection.
- Sits between pipeline stages of the processor: operand/forwarding select with stall back-pressure and bubble insertion.

Parameters:
- WIDTH, 16, bits per data word.
- NUM_IN, 4, number of selectable inputs, 2..8.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_data  input  NUM_IN*WIDTH  flat input bus; word i is in_data[i*WIDTH +: WIDTH].
- sel  input  SEL_W  input select, sampled on accept.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  discard all held and incoming words.
- out_data  output  WIDTH  head word.
- out_sel_err  output  1  head word was accepted with sel >= NUM_IN.
- out_valid  output  1  head word valid.
- out_ready  input  1  downstream consumes head this cycle.
- occ  output  2  occupancy, 0..2.

Behaviour:
- Accept = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the same rising edge.
- Selected word = word[sel] when sel < NUM_IN; otherwise all-zeros with err flag 1. The err flag travels with the word.
- Storage is a head register H (drives the outputs) and a skid register S. Each holds data, err and valid.
- States by occupancy:
  - EMPTY(0): accept -> ONE, word loaded into H.
  - ONE(1):
    - accept & pop -> ONE, H replaced by the new word.
    - accept & ~pop -> TWO, word loaded into S.
    - pop & ~accept -> EMPTY.
    - neither -> ONE, H held.
  - TWO(2): in_ready=0, so no accept is possible.
    - pop -> ONE, S moves to H and S is cleared.
    - else -> TWO, held.
- in_ready = ~rst & ~flush & (occ != 2). This is combinational from registered state and flush only; there is no in_valid->in_ready path.
- Latency: a word accepted at edge k is visible on out_data/out_valid after edge k. One cycle when EMPTY.
- Throughput: one word per cycle when out_ready is held high.
- Order is strictly FIFO. H never goes invalid while S is valid.
- flush, next edge:
  - All valids cleared; occ=0.
  - A pop in the same cycle still counts as consumed.
  - in_ready=0 during flush, so no accept can occur.
  - Data registers keep their values (don't-care).
- rst, next edge:
  - out_valid=0, occ=0, out_data=0, out_sel_err=0, S cleared.
  - in_ready=0 while rst is high.
  - rst overrides flush, accept and pop. Reset mid-transfer drops the held words silently.
- out_data, out_sel_err and out_valid are register outputs only, with no combinational path from the inputs.
- occ is registered and equals H.valid + S.valid.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel_err are stable.

Decomposition:
- Shared header (Verilog include) holds the occupancy encodings OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
- One sub-module: pipe_word_reg, a (WIDTH+2)-bit register (data, err, valid) with load enable and synchronous clear. Built from the team's dff cells and instantiated twice, as H and S.
- Select logic is a generate loop over NUM_IN in the top.

Test Plan (WIDTH=16, NUM_IN=4):
- Reset, then idle:
  - rst=1 for 2 cycles -> out_valid=0, out_data=0, occ=0, in_ready=0.
  - After rst falls -> in_ready=1.
- Basic select:
  - Inputs {word3..0}={0xDDDD,0xCCCC,0xBBBB,0xAAAA}, sel=2, in_valid one cycle, out_ready=1 -> next cycle out_data=0xCCCC, out_valid=1, out_sel_err=0, occ=1.
  - Following cycle -> out_valid=0.
- Streaming:
  - sel=0,1,2,3 on consecutive cycles with out_ready=1 -> outputs 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD on consecutive cycles.
  - in_ready stays 1 and occ never exceeds 1.
- Backpressure and skid:
  - out_ready=0, push sel=1 then sel=3 -> occ=2, in_ready=0, out_data=0xBBBB held.
  - Third push attempt is not accepted.
  - Raise out_ready -> 0xBBBB, then 0xDDDD, then out_valid=0.
- Out-of-range select: generic NUM_IN=3 instance, sel=3 -> out_data=0x0000, out_sel_err=1, out_valid=1.
- Flush and reset mid-operation:
  - With occ=2, assert flush with in_valid=1 -> next cycle occ=0, out_valid=0; the flush-cycle word is not accepted.
  - Refill to occ=2 and assert rst with flush=1 -> all outputs at their reset values.
